// File: rtl/fcims_order_seq_pkg.sv
// Shared definitions for the food-court order sequencer: op codes, response codes,
// FSM state encoding and default widths.
package fcims_order_seq_pkg;

    localparam int DEF_NUM_ITEMS = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_BW        = 2 * DEF_W;

    localparam logic [1:0] OP_SELL     = 2'd0;
    localparam logic [1:0] OP_RESTOCK  = 2'd1;
    localparam logic [1:0] OP_SETPRICE = 2'd2;
    localparam logic [1:0] OP_CHECKOUT = 2'd3;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_NO_STOCK  = 2'd1;
    localparam logic [1:0] ERR_STOCK_OVF = 2'd2;
    localparam logic [1:0] ERR_BILL_OVF  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/fcims_order_seq_if.sv
// Command/response bundle between the order front-end (master) and the sequencer (slave).
interface fcims_order_seq_if #(
    parameter int IW = 2,
    parameter int W  = 4,
    parameter int BW = 8
);

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [IW-1:0] req_item;
    logic [W-1:0]  req_val;
    logic          resp_valid;
    logic [1:0]    resp_err;
    logic [BW-1:0] resp_fprice;
    logic [W-1:0]  resp_stock;
    logic [BW-1:0] bill;

    modport master (
        output req_valid, req_op, req_item, req_val,
        input  req_ready, resp_valid, resp_err, resp_fprice, resp_stock, bill
    );

    modport slave (
        input  req_valid, req_op, req_item, req_val,
        output req_ready, resp_valid, resp_err, resp_fprice, resp_stock, bill
    );

endinterface

// File: rtl/fcims_order_seq_item_table.sv
// Per-item {price, stock} register file: one async read port, one write port with
// independent price/stock enables. Out-of-range indices read as 0 and never write.
module fcims_order_seq_item_table #(
    parameter int NUM_ITEMS = 4,
    parameter int W         = 4,
    parameter int IW        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx_i,
    output logic [W-1:0]  rd_price_o,
    output logic [W-1:0]  rd_stock_o,
    input  logic [IW-1:0] wr_idx_i,
    input  logic          price_we_i,
    input  logic          stock_we_i,
    input  logic [W-1:0]  wr_price_i,
    input  logic [W-1:0]  wr_stock_i
);

    logic [W-1:0] price_q [NUM_ITEMS];
    logic [W-1:0] stock_q [NUM_ITEMS];

    logic rd_ok;
    logic wr_ok;

    assign rd_ok = int'(rd_idx_i) < NUM_ITEMS;
    assign wr_ok = int'(wr_idx_i) < NUM_ITEMS;

    always_comb begin
        rd_price_o = '0;
        rd_stock_o = '0;
        if (rd_ok) begin
            rd_price_o = price_q[rd_idx_i];
            rd_stock_o = stock_q[rd_idx_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= '0;
                stock_q[i] <= '0;
            end
        end else begin
            if (price_we_i && wr_ok) price_q[wr_idx_i] <= wr_price_i;
            if (stock_we_i && wr_ok) stock_q[wr_idx_i] <= wr_stock_i;
        end
    end

endmodule

// File: rtl/fcims_order_seq.sv
// Order sequencer: accepts one command at a time, evaluates it against the item table
// and bill register in EXEC, commits state and registers the response, pulses it in RESP.
module fcims_order_seq
    import fcims_order_seq_pkg::*;
#(
    parameter int NUM_ITEMS = DEF_NUM_ITEMS,
    parameter int W         = DEF_W,
    parameter int BW        = 2 * W
) (
    input logic              clk,
    input logic              rst_n,
    fcims_order_seq_if.slave bus
);

    localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [IW-1:0] item_q, item_d;
    logic [W-1:0]  val_q, val_d;
    logic [BW-1:0] bill_q, bill_d;
    logic [1:0]    resp_err_q, resp_err_d;
    logic [BW-1:0] resp_fprice_q, resp_fprice_d;
    logic [W-1:0]  resp_stock_q, resp_stock_d;

    logic [W-1:0]  rd_price;
    logic [W-1:0]  rd_stock;
    logic          price_we;
    logic          stock_we;
    logic [W-1:0]  wr_stock;
    logic          item_ok;
    logic [BW-1:0] fp;
    logic [BW:0]   bill_sum;
    logic [W:0]    stock_sum;

    fcims_order_seq_item_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .W         (W),
        .IW        (IW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (item_q),
        .rd_price_o (rd_price),
        .rd_stock_o (rd_stock),
        .wr_idx_i   (item_q),
        .price_we_i (price_we),
        .stock_we_i (stock_we),
        .wr_price_i (val_q),
        .wr_stock_i (wr_stock)
    );

    // Full-width product and one-bit-wider sums expose overflow without truncation.
    assign item_ok   = int'(item_q) < NUM_ITEMS;
    assign fp        = BW'(val_q) * BW'(rd_price);
    assign bill_sum  = {1'b0, bill_q} + {1'b0, fp};
    assign stock_sum = {1'b0, rd_stock} + {1'b0, val_q};

    assign bus.req_ready   = rst_n && (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_fprice = resp_fprice_q;
    assign bus.resp_stock  = resp_stock_q;
    assign bus.bill        = bill_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        item_d        = item_q;
        val_d         = val_q;
        bill_d        = bill_q;
        resp_err_d    = resp_err_q;
        resp_fprice_d = resp_fprice_q;
        resp_stock_d  = resp_stock_q;
        price_we      = 1'b0;
        stock_we      = 1'b0;
        wr_stock      = rd_stock;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    op_d    = bus.req_op;
                    item_d  = bus.req_item;
                    val_d   = bus.req_val;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d       = ST_RESP;
                resp_err_d    = ERR_OK;
                resp_fprice_d = '0;
                resp_stock_d  = rd_stock;
                case (op_q)
                    OP_SELL: begin
                        resp_fprice_d = fp;
                        // Stock shortage outranks bill overflow.
                        if (!item_ok || (rd_stock < val_q)) begin
                            resp_err_d = ERR_NO_STOCK;
                        end else if (bill_sum[BW]) begin
                            resp_err_d = ERR_BILL_OVF;
                        end else begin
                            stock_we     = 1'b1;
                            wr_stock     = rd_stock - val_q;
                            resp_stock_d = wr_stock;
                            bill_d       = bill_sum[BW-1:0];
                        end
                    end
                    OP_RESTOCK: begin
                        if (!item_ok) begin
                            resp_err_d = ERR_NO_STOCK;
                        end else if (stock_sum[W]) begin
                            resp_err_d = ERR_STOCK_OVF;
                        end else begin
                            stock_we     = 1'b1;
                            wr_stock     = stock_sum[W-1:0];
                            resp_stock_d = wr_stock;
                        end
                    end
                    OP_SETPRICE: begin
                        price_we = item_ok;
                    end
                    default: begin
                        resp_fprice_d = bill_q;
                        bill_d        = '0;
                    end
                endcase
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_SELL;
            item_q        <= '0;
            val_q         <= '0;
            bill_q        <= '0;
            resp_err_q    <= ERR_OK;
            resp_fprice_q <= '0;
            resp_stock_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            item_q        <= item_d;
            val_q         <= val_d;
            bill_q        <= bill_d;
            resp_err_q    <= resp_err_d;
            resp_fprice_q <= resp_fprice_d;
            resp_stock_q  <= resp_stock_d;
        end
    end

endmodule

// File: tb/tb_fcims_order_seq.sv
// Directed bench for fcims_order_seq: a command/expected-response table plus
// hand-written sequences for back-to-back acceptance and mid-command reset.
module tb_fcims_order_seq;
    import fcims_order_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fcims_order_seq_if #(.IW(2), .W(4), .BW(8)) bus ();

    fcims_order_seq #(.NUM_ITEMS(4), .W(4), .BW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [1:0] item;
        logic [3:0] val;
        logic [1:0] err;
        logic [7:0] fp;
        logic [3:0] stock;
        logic [7:0] bill;
    } vec_t;

    localparam int NV = 27;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issues one command, scrambles the request fields while busy, and returns at the
    // falling edge where resp_valid is observed (or after the bound expires).
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] item, input logic [3:0] val,
                          input string nm, output bit got);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_item  = item;
        bus.req_val   = val;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom);
        bus.req_item  = 2'($urandom);
        bus.req_val   = 4'($urandom);
        chk({nm, "_exec_quiet"}, 32'(bus.resp_valid), 32'd0);
        n = 0;
        while (!bus.resp_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        got = bus.resp_valid;
        chk({nm, "_resp_lat"}, 32'(n), 32'd1);
    endtask

    initial begin
        bit got;
        int acc_cycle [4];
        int nacc;
        int npulse;
        int cyc;

        errors = 0;
        checks = 0;

        tv[0]  = '{OP_SETPRICE, 2'd2, 4'd5,  ERR_OK,        8'd0,   4'd0,  8'd0};
        tv[1]  = '{OP_RESTOCK,  2'd2, 4'd10, ERR_OK,        8'd0,   4'd10, 8'd0};
        tv[2]  = '{OP_SELL,     2'd2, 4'd3,  ERR_OK,        8'd15,  4'd7,  8'd15};
        tv[3]  = '{OP_SELL,     2'd2, 4'd8,  ERR_NO_STOCK,  8'd40,  4'd7,  8'd15};
        tv[4]  = '{OP_SELL,     2'd2, 4'd0,  ERR_OK,        8'd0,   4'd7,  8'd15};
        tv[5]  = '{OP_CHECKOUT, 2'd2, 4'd9,  ERR_OK,        8'd15,  4'd7,  8'd0};
        tv[6]  = '{OP_SETPRICE, 2'd1, 4'd15, ERR_OK,        8'd0,   4'd0,  8'd0};
        tv[7]  = '{OP_RESTOCK,  2'd1, 4'd15, ERR_OK,        8'd0,   4'd15, 8'd0};
        tv[8]  = '{OP_SETPRICE, 2'd0, 4'd10, ERR_OK,        8'd0,   4'd0,  8'd0};
        tv[9]  = '{OP_RESTOCK,  2'd0, 4'd4,  ERR_OK,        8'd0,   4'd4,  8'd0};
        tv[10] = '{OP_SELL,     2'd0, 4'd4,  ERR_OK,        8'd40,  4'd0,  8'd40};
        tv[11] = '{OP_SELL,     2'd1, 4'd15, ERR_BILL_OVF,  8'd225, 4'd15, 8'd40};
        tv[12] = '{OP_SELL,     2'd0, 4'd1,  ERR_NO_STOCK,  8'd10,  4'd0,  8'd40};
        tv[13] = '{OP_RESTOCK,  2'd3, 4'd12, ERR_OK,        8'd0,   4'd12, 8'd40};
        tv[14] = '{OP_RESTOCK,  2'd3, 4'd4,  ERR_STOCK_OVF, 8'd0,   4'd12, 8'd40};
        tv[15] = '{OP_RESTOCK,  2'd3, 4'd3,  ERR_OK,        8'd0,   4'd15, 8'd40};
        tv[16] = '{OP_RESTOCK,  2'd3, 4'd0,  ERR_OK,        8'd0,   4'd15, 8'd40};
        tv[17] = '{OP_CHECKOUT, 2'd3, 4'd0,  ERR_OK,        8'd40,  4'd15, 8'd0};
        tv[18] = '{OP_SELL,     2'd1, 4'd1,  ERR_OK,        8'd15,  4'd14, 8'd15};
        tv[19] = '{OP_CHECKOUT, 2'd1, 4'd0,  ERR_OK,        8'd15,  4'd14, 8'd0};
        tv[20] = '{OP_SETPRICE, 2'd2, 4'd15, ERR_OK,        8'd0,   4'd7,  8'd0};
        tv[21] = '{OP_RESTOCK,  2'd2, 4'd8,  ERR_OK,        8'd0,   4'd15, 8'd0};
        tv[22] = '{OP_SELL,     2'd2, 4'd15, ERR_OK,        8'd225, 4'd0,  8'd225};
        tv[23] = '{OP_SELL,     2'd1, 4'd2,  ERR_OK,        8'd30,  4'd12, 8'd255};
        tv[24] = '{OP_SELL,     2'd1, 4'd1,  ERR_BILL_OVF,  8'd15,  4'd12, 8'd255};
        tv[25] = '{OP_SELL,     2'd2, 4'd1,  ERR_NO_STOCK,  8'd15,  4'd0,  8'd255};
        tv[26] = '{OP_CHECKOUT, 2'd0, 4'd0,  ERR_OK,        8'd255, 4'd0,  8'd0};

        bus.req_valid = 1'b0;
        bus.req_op    = OP_SELL;
        bus.req_item  = 2'd0;
        bus.req_val   = 4'd0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",  32'(bus.req_ready),   32'd1);
        chk("rst_rvalid", 32'(bus.resp_valid),  32'd0);
        chk("rst_bill",   32'(bus.bill),        32'd0);
        chk("rst_err",    32'(bus.resp_err),    32'd0);
        chk("rst_fprice", 32'(bus.resp_fprice), 32'd0);
        chk("rst_stock",  32'(bus.resp_stock),  32'd0);

        for (int i = 0; i < NV; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            do_cmd(tv[i].op, tv[i].item, tv[i].val, nm, got);
            chk({nm, "_rvalid"}, 32'(got), 32'd1);
            chk({nm, "_err"},    32'(bus.resp_err),    32'(tv[i].err));
            chk({nm, "_fprice"}, 32'(bus.resp_fprice), 32'(tv[i].fp));
            chk({nm, "_stock"},  32'(bus.resp_stock),  32'(tv[i].stock));
            chk({nm, "_bill"},   32'(bus.bill),        32'(tv[i].bill));
            @(negedge clk);
            chk({nm, "_pulse1"}, 32'(bus.resp_valid), 32'd0);
        end

        // Continuous req_valid: acceptances land every third cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_CHECKOUT;
        bus.req_item  = 2'd0;
        bus.req_val   = 4'd0;
        nacc   = 0;
        npulse = 0;
        cyc    = 0;
        while (nacc < 4 && cyc < 20) begin
            if (bus.req_ready && bus.req_valid) begin
                acc_cycle[nacc] = cyc;
                nacc++;
            end
            if (bus.resp_valid) npulse++;
            @(negedge clk);
            cyc++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd4);
        for (int k = 1; k < 4; k++) begin
            if (k < nacc) chk($sformatf("b2b_gap%0d", k), 32'(acc_cycle[k] - acc_cycle[k-1]), 32'd3);
        end
        chk("b2b_pulses", 32'(npulse), 32'd3);
        repeat (3) @(negedge clk);
        chk("b2b_idle_bill", 32'(bus.bill), 32'd0);

        // Abort a SELL mid-execution with reset.
        do_cmd(OP_SETPRICE, 2'd1, 4'd3, "ab_setp", got);
        do_cmd(OP_RESTOCK,  2'd1, 4'd5, "ab_rest", got);
        do_cmd(OP_SELL,     2'd1, 4'd2, "ab_sell0", got);
        chk("ab_pre_bill", 32'(bus.bill), 32'd6);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SELL;
        bus.req_item  = 2'd1;
        bus.req_val   = 4'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ab_bill_async", 32'(bus.bill),       32'd0);
        chk("ab_rvalid_rst", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) npulse++;
            @(negedge clk);
        end
        chk("ab_no_pulse", 32'(npulse), 32'd0);
        chk("ab_ready",    32'(bus.req_ready), 32'd1);
        chk("ab_bill",     32'(bus.bill), 32'd0);
        do_cmd(OP_SELL, 2'd1, 4'd1, "ab_probe", got);
        chk("ab_probe_err",    32'(bus.resp_err),    32'(ERR_NO_STOCK));
        chk("ab_probe_fprice", 32'(bus.resp_fprice), 32'd0);
        chk("ab_probe_stock",  32'(bus.resp_stock),  32'd0);
        chk("ab_probe_bill",   32'(bus.bill),        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
